// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings and latency limit.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    DmIdle = 2'd0,
    DmWait = 2'd1,
    DmDone = 2'd2
  } dm_state_e;

  localparam int DmLatMax = 15;

endpackage

// File: rtl/dm_responder_array.sv
// Single-port synchronous word RAM with registered read; kept apart from the
// control FSM so a hard SRAM macro can replace it without touching the FSM.
module dm_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Read-first: a same-cycle write is not visible on rdata until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/dm_responder.sv
// MEM-stage data-memory responder: accepts one load/store at a time, completes it
// after a fixed latency with a one-cycle ack, and stalls the pipeline meanwhile.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_DM_read,
  input  logic              mem_DM_write,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_sw_o,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              dm_misalign
);

  localparam int CNT_W = $clog2(DmLatMax + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  dm_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  write_reg;
  logic                  cur_mis_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W-1:0]     rdata_hold_reg;
  logic                  ack_reg;
  logic                  misalign_reg;

  logic                  req;
  logic                  addr_mis;
  logic [DEPTH_LOG2-1:0] req_index;
  logic [DEPTH_LOG2-1:0] ram_index;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DATA_W-1:0]     load_data;
  logic                  unused_addr_hi;

  assign req       = mem_DM_read | mem_DM_write;
  assign addr_mis  = |mem_alu_result[1:0];
  assign req_index = mem_alu_result[DEPTH_LOG2+1:2];
  // Upper address bits are dropped on purpose so accesses wrap around the array.
  assign unused_addr_hi = ^mem_alu_result[DATA_W-1:DEPTH_LOG2+2];

  // In IDLE the RAM looks at the live address so a LATENCY=1 read has its data on entry to DONE.
  assign ram_index = (state_reg == DmIdle) ? req_index : idx_reg;
  assign ram_we    = (state_reg == DmDone) & write_reg & ~cur_mis_reg;

  dm_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .index (ram_index),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      DmIdle: begin
        if (req) begin
          state_next = (LATENCY == 1) ? DmDone : DmWait;
          cnt_next   = CNT_INIT;
        end
      end
      DmWait: begin
        if (cnt_reg == '0) begin
          state_next = DmDone;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DmDone: begin
        state_next = DmIdle;
      end
      default: begin
        state_next = DmIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= DmIdle;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= (state_next == DmDone);
    end
  end

  // Request capture; both strobes high resolves to a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg    <= 1'b0;
      cur_mis_reg  <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      misalign_reg <= 1'b0;
    end else if ((state_reg == DmIdle) && req) begin
      write_reg   <= mem_DM_write;
      cur_mis_reg <= addr_mis;
      idx_reg     <= req_index;
      wdata_reg   <= mem_sw_o;
      if (addr_mis) begin
        misalign_reg <= 1'b1;
      end
    end
  end

  assign load_data = cur_mis_reg ? '0 : ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold_reg <= '0;
    end else if ((state_reg == DmDone) && !write_reg) begin
      rdata_hold_reg <= load_data;
    end
  end

  assign dm_rdata    = ((state_reg == DmDone) && !write_reg) ? load_data : rdata_hold_reg;
  assign dm_ack      = ack_reg;
  assign dm_stall    = req & (state_reg != DmDone) & ~rst;
  assign dm_misalign = misalign_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: LATENCY=2 instance for the main sequence,
// a LATENCY=1 instance for the short-latency case.
module tb_dm_responder;

  typedef struct {
    logic        is_read;
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  logic        clk;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [31:0] rdata0, rdata1;
  logic        ack0, ack1, stall0, stall1, mis0, mis1;

  int passed = 0;
  int total  = 0;
  sb_item_t q0[$];
  sb_item_t q1[$];
  sb_item_t m0, m1;

  dm_responder #(.DATA_W(32), .DEPTH_LOG2(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .mem_DM_read(rd0), .mem_DM_write(wr0),
    .mem_alu_result(addr0), .mem_sw_o(wd0), .dm_rdata(rdata0),
    .dm_ack(ack0), .dm_stall(stall0), .dm_misalign(mis0)
  );

  dm_responder #(.DATA_W(32), .DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_DM_read(rd1), .mem_DM_write(wr1),
    .mem_alu_result(addr1), .mem_sw_o(wd1), .dm_rdata(rdata1),
    .dm_ack(ack1), .dm_stall(stall1), .dm_misalign(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected response per ack.
  always @(negedge clk) begin
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        total++;
        $display("FAIL dut0_unexpected_ack: got ack=1 expected no ack");
      end else begin
        m0 = q0.pop_front();
        if (m0.is_read) check(m0.name, rdata0, m0.exp);
        $display("dut0 ack %s rdata=%h", m0.name, rdata0);
      end
    end
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL dut1_unexpected_ack: got ack=1 expected no ack");
      end else begin
        m1 = q1.pop_front();
        if (m1.is_read) check(m1.name, rdata1, m1.exp);
        $display("dut1 ack %s rdata=%h", m1.name, rdata1);
      end
    end
  end

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after DONE.
  task automatic access(input int which, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rdata, input string name);
    int lat = (which == 0) ? 2 : 1;
    sb_item_t it;
    it.is_read = rd & ~wr;
    it.exp     = exp_rdata;
    it.name    = name;
    if (which == 0) begin
      rd0 = rd; wr0 = wr; addr0 = addr; wd0 = data;
      q0.push_back(it);
    end else begin
      rd1 = rd; wr1 = wr; addr1 = addr; wd1 = data;
      q1.push_back(it);
    end
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      check({name, "_stall"}, (which == 0) ? stall0 : stall1, 1'b1);
      check({name, "_noack"}, (which == 0) ? ack0 : ack1, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({name, "_stall_done"}, (which == 0) ? stall0 : stall1, 1'b0);
    check({name, "_ack"}, (which == 0) ? ack0 : ack1, 1'b1);
    @(posedge clk); #1;
    if (which == 0) begin
      rd0 = 1'b0; wr0 = 1'b0;
    end else begin
      rd1 = 1'b0; wr1 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'h0; wd0 = 32'h0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wd1 = 32'h0;
    @(negedge clk);
    check("stall_in_reset", stall0, 1'b0);
    rd0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_stall", stall0, 1'b0);
      check("idle_ack", ack0, 1'b0);
      check("idle_rdata", rdata0, 32'h0);
    end
    check("idle_misalign", mis0, 1'b0);
    @(posedge clk); #1;

    // 2: store then load
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, "st_10");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "ld_10");
    @(negedge clk);
    check("rdata_held", rdata0, 32'hDEADBEEF);
    @(posedge clk); #1;

    // 3: back-to-back read-after-write
    access(0, 1'b0, 1'b1, 32'h20, 32'h1, 32'h0, "st_20");
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1, "ld_20");

    // 4: address wrap
    access(0, 1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 32'h0, "st_1000");
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, "ld_0_wrap");

    // 5: misaligned store and load
    check("misalign_clear", mis0, 1'b0);
    access(0, 1'b0, 1'b1, 32'h22, 32'h55, 32'h0, "st_22_mis");
    check("misalign_set", mis0, 1'b1);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1, "ld_20_unchanged");
    access(0, 1'b1, 1'b0, 32'h23, 32'h0, 32'h0, "ld_23_mis");
    check("misalign_sticky", mis0, 1'b1);

    // 6: reset mid-store
    access(0, 1'b0, 1'b1, 32'h30, 32'h1234, 32'h0, "st_30");
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h1234, "ld_30_pre");
    wr0 = 1'b1; addr0 = 32'h30; wd0 = 32'h77;
    @(posedge clk); #1;
    check("abort_stall_wait", stall0, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_ack", ack0, 1'b0);
    check("abort_stall", stall0, 1'b0);
    check("abort_rdata", rdata0, 32'h0);
    check("abort_misalign", mis0, 1'b0);
    wr0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h1234, "ld_30_post");

    // 7: both strobes high is a write
    access(0, 1'b1, 1'b1, 32'h40, 32'h9, 32'h0, "both_40");
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h9, "ld_40");

    // 8: LATENCY=1 instance
    access(1, 1'b0, 1'b1, 32'h8, 32'h3C, 32'h0, "l1_st_8");
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h3C, "l1_ld_8");

    repeat (3) @(posedge clk);
    check("sb0_drained", 32'(q0.size()), 32'h0);
    check("sb1_drained", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder at the MEM end of the EXE/MEM pipeline interface.
- Consumes the MEM-stage request signals: DM read/write strobes, ALU-result address and store data.
- Services each request from an internal word array with a programmable access latency, and returns load data with a one-cycle acknowledge.
- Holds the pipeline through a stall output while an access is in flight.

Parameters:
- DATA_W, 32, data width; matches RegBus.
- DEPTH_LOG2, 10, log2 of array depth in words (1024 words).
- LATENCY, 2, cycles from request accept to completion; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_DM_read  in  1  load request; held stable by the pipeline while dm_stall=1.
- mem_DM_write  in  1  store request; held stable while dm_stall=1.
- mem_alu_result  in  DATA_W  byte address.
- mem_sw_o  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid when dm_ack=1 and the request was a read; held afterwards.
- dm_ack  out  1  one-cycle pulse on the completion cycle.
- dm_stall  out  1  freezes the IF..EXE/MEM registers.
- dm_misalign  out  1  sticky flag: an access had addr[1:0]!=0.

Behaviour:
Reset:
- Asynchronous: state=IDLE, counter=0, dm_rdata=0, dm_ack=0, dm_misalign=0.
- Array contents are not cleared by reset.

Request:
- req = mem_DM_read | mem_DM_write.
- If both strobes are high, the access is treated as a write.

FSM states and transitions:
- IDLE:
  - req=1: latch op, word index addr[DEPTH_LOG2+1:2] and store data.
  - LATENCY=1: go to DONE; otherwise go to WAIT with counter=LATENCY-2.
  - req=0: stay in IDLE.
- WAIT:
  - counter=0: go to DONE; otherwise decrement the counter.
- DONE:
  - dm_ack=1 (registered output, high for exactly this cycle).
  - Write: array[index] updated at the end of this cycle.
  - Read: dm_rdata = array[index], registered on entry to DONE.
  - Next state: IDLE unconditionally.

Stall and timing:
- dm_stall is combinational: req & (state != DONE).
- The pipeline advances at the end of the DONE cycle, so the next request is seen in IDLE one cycle later.
- Request to ack is exactly LATENCY cycles. Throughput is one access per LATENCY+1 cycles.

Address and alignment:
- Address bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo the array size.
- Misaligned access (addr[1:0]!=0):
  - The FSM still runs and the ack still pulses.
  - A write is suppressed; a read returns 0.
  - dm_misalign sets and stays set until rst.

Hazards and boundary conditions:
- Read-after-write to the same index in consecutive requests returns the new data. The write commits before the next request is accepted, so no bypass is needed.
- Request strobes changing while in WAIT are ignored; the latched values are used.
- A request that drops to 0 in WAIT is still completed; this is a protocol violation and is not flagged.
- Reset mid-access: the access is abandoned, no array write occurs, and dm_ack and dm_stall go to 0.
- dm_stall is 0 during reset.

Decomposition:
- Shared package port_define additions:
  - DmIdle, DmWait and DmDone state encodings (2-bit enum).
  - DmLatMax=15.
- Sub-module dm_array: single-port synchronous word RAM.
  - Ports: clk, we, index, wdata, rdata.
  - Registered read, no reset.
  - Keeps the FSM separate from the storage so an SRAM macro can be substituted later.

Test Plan:
1. Reset then idle, LATENCY=2, no strobes -> dm_stall=0, dm_ack=0, dm_rdata=0 for 10 cycles.
2. Store 0xDEADBEEF to addr 0x10, then load from addr 0x10 -> for each access dm_stall=1 for 2 cycles and ack pulses on cycle 2. The load returns 0xDEADBEEF.
3. Back-to-back store 0x1 to 0x20 then immediate load from 0x20 -> load returns 0x1; no idle gap beyond the single IDLE cycle.
4. Wrap: store 0xA5A5A5A5 to 0x1000 (DEPTH_LOG2=10), then load from 0x0 -> 0xA5A5A5A5.
5. Misaligned store of 0x55 to 0x22 -> ack pulses, dm_misalign=1 and stays set. A later load from 0x20 returns the prior contents unchanged; a load from 0x23 returns 0.
6. Assert rst in the WAIT cycle of a store of 0x77 to 0x30 -> all outputs return to 0 immediately. A following load from 0x30 returns the prior value, not 0x77.
7. Both strobes high with store data 0x9 to 0x40 -> treated as a write; a load from 0x40 then returns 0x9.
8. LATENCY=1 build -> stall lasts 1 cycle and ack follows on the next cycle.
